// File: rtl/booth_mul_sched_pkg.sv
// booth_mul_sched_pkg
// Shared definitions for the Booth multiplier scheduler: the controller state
// encoding, default sizing constants and an index-width helper.
package booth_mul_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_LDQ,
    ST_LDM,
    ST_WAIT,
    ST_RESP
  } state_e;

  localparam int DEF_NREQ    = 4;
  localparam int DEF_WIDTH   = 16;
  localparam int DEF_TIMEOUT = 64;

  // Width needed to hold an index 0..n-1, never less than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/booth_mul_sched_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin arbiter. Searches req starting at position ptr
// and wrapping around; the first asserted request wins.
// Ports:
//   req   in  NREQ  request vector
//   ptr   in  IW    highest-priority position for this search
//   grant out NREQ  one-hot grant (all zero when no request)
//   idx   out IW    encoded index of the granted requester
//   any   out 1     at least one request present
module rr_arbiter
  import booth_mul_sched_pkg::*;
#(
  parameter  int NREQ = DEF_NREQ,
  localparam int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  always_comb begin
    int pos;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    for (int i = 0; i < NREQ; i++) begin
      pos = int'(ptr) + i;
      if (pos >= NREQ) pos = pos - NREQ;
      if (!any && req[pos]) begin
        any        = 1'b1;
        grant[pos] = 1'b1;
        idx        = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/booth_mul_sched.sv
// booth_mul_sched
// Round-robin scheduler sharing one sequential Booth multiplier engine among
// NREQ requesters. Grants one request, pulses the engine start, loads the
// multiplier then the multiplicand over eng_data, waits for the rising edge
// of eng_done and presents the product with the requester index.
// Optional feature: define BOOTH_MUL_SCHED_TIMEOUT_EN to add a WAIT-state
// watchdog that answers with rsp_err=1, rsp_product=0 after TIMEOUT cycles.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready per-requester handshake (ready is a one-hot pulse)
//   req_a, req_b        packed multiplicands / multipliers, slice i = req i
//   rsp_valid/rsp_ready response handshake
//   rsp_id, rsp_product, rsp_err  served index, signed product, timeout flag
//   eng_start, eng_data engine start pulse and operand bus
//   eng_done, eng_product engine done level and {A,Q} result
module booth_mul_sched
  import booth_mul_sched_pkg::*;
#(
  parameter  int NREQ    = DEF_NREQ,
  parameter  int WIDTH   = DEF_WIDTH,
  parameter  int TIMEOUT = DEF_TIMEOUT,
  localparam int IW      = idx_w(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [NREQ-1:0]         req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IW-1:0]           rsp_id,
  output logic [2*WIDTH-1:0]      rsp_product,
  output logic                    rsp_err,
  output logic                    eng_start,
  output logic [WIDTH-1:0]        eng_data,
  input  logic                    eng_done,
  input  logic [2*WIDTH-1:0]      eng_product
);

  state_e                state_q, state_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic                  done_q;
  logic [WIDTH-1:0]      a_q, a_d;
  logic [WIDTH-1:0]      b_q, b_d;
  logic [IW-1:0]         id_q, id_d;
  logic [2*WIDTH-1:0]    prod_q, prod_d;
  logic                  done_rise;

  logic [NREQ-1:0]       arb_grant;
  logic [IW-1:0]         arb_idx;
  logic                  arb_any;

`ifdef BOOTH_MUL_SCHED_TIMEOUT_EN
  localparam int CW = idx_w(TIMEOUT);
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  err_q, err_d;
`else
  // Keeps TIMEOUT referenced when the watchdog is compiled out.
  logic                  unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // done_q resets to 1 so a done level held across reset is not an edge.
  assign done_rise = eng_done & ~done_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    a_d     = a_q;
    b_d     = b_q;
    id_d    = id_q;
    prod_d  = prod_q;
`ifdef BOOTH_MUL_SCHED_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          a_d     = req_a[int'(arb_idx)*WIDTH +: WIDTH];
          b_d     = req_b[int'(arb_idx)*WIDTH +: WIDTH];
          id_d    = arb_idx;
          ptr_d   = (int'(arb_idx) == NREQ-1) ? '0 : arb_idx + 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: state_d = ST_LDQ;
      ST_LDQ:   state_d = ST_LDM;
      ST_LDM: begin
`ifdef BOOTH_MUL_SCHED_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_rise) begin
          prod_d  = eng_product;
`ifdef BOOTH_MUL_SCHED_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = ST_RESP;
        end
`ifdef BOOTH_MUL_SCHED_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT-1)) begin
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
`endif
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      done_q  <= 1'b1;
      id_q    <= '0;
      prod_q  <= '0;
`ifdef BOOTH_MUL_SCHED_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      done_q  <= eng_done;
      id_q    <= id_d;
      prod_q  <= prod_d;
`ifdef BOOTH_MUL_SCHED_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // Operand holding registers: only read in LDQ/LDM, so no reset needed.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  // Outputs decoded from state or taken straight from registers.
  always_comb begin
    req_ready = '0;
    eng_data  = '0;
    if (state_q == ST_IDLE && !rst) req_ready = arb_grant;
    if (state_q == ST_LDQ) eng_data = b_q;
    if (state_q == ST_LDM) eng_data = a_q;
  end

  assign eng_start   = (state_q == ST_START);
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_id      = id_q;
  assign rsp_product = prod_q;
`ifdef BOOTH_MUL_SCHED_TIMEOUT_EN
  assign rsp_err     = err_q;
`else
  assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_booth_mul_sched.sv
// tb_booth_mul_sched
// Directed bench for booth_mul_sched with a small behavioural engine stub.
// Optional section exercises BOOTH_MUL_SCHED_TIMEOUT_EN with TIMEOUT = 16.
`timescale 1ns/1ps
module tb_booth_mul_sched;
  localparam int NREQ    = 4;
  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 16;
  localparam int IW      = 2;
  localparam int LAT     = 5;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid, rsp_ready;
  logic [IW-1:0]         rsp_id;
  logic [2*WIDTH-1:0]    rsp_product;
  logic                  rsp_err;
  logic                  eng_start;
  logic [WIDTH-1:0]      eng_data;
  logic                  eng_done = 1'b0;
  logic [2*WIDTH-1:0]    eng_product = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  booth_mul_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .rsp_err     (rsp_err),
    .eng_start   (eng_start),
    .eng_data    (eng_data),
    .eng_done    (eng_done),
    .eng_product (eng_product)
  );

  // Engine stub: drops done on start, takes Q then M, raises done LAT cycles later.
  logic [1:0]              ph_q  = '0;
  int                      cnt_q = 0;
  logic signed [WIDTH-1:0] q_q   = '0;
  logic signed [WIDTH-1:0] m_q   = '0;
  logic                    done_en;

  always @(posedge clk) begin
    if (eng_start) begin
      ph_q     <= 2'd1;
      eng_done <= 1'b0;
    end else begin
      case (ph_q)
        2'd1: begin q_q <= eng_data; ph_q <= 2'd2; end
        2'd2: begin m_q <= eng_data; ph_q <= 2'd3; cnt_q <= 0; end
        2'd3: begin
          cnt_q <= cnt_q + 1;
          if (done_en && cnt_q >= LAT-1) begin
            eng_done    <= 1'b1;
            eng_product <= m_q * q_q;
            ph_q        <= 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[id*WIDTH +: WIDTH] = a;
    req_b[id*WIDTH +: WIDTH] = b;
  endtask

  task automatic grant_wait(input int exp_id, input string tag);
    int n;
    n = 0;
    #1;
    while (req_ready == '0 && n < 100) begin
      tick();
      n++;
    end
    check_val(tag, req_ready, 64'(1) << exp_id);
  endtask

  task automatic rsp_wait(input int exp_id, input logic [31:0] exp_prod, input logic exp_err,
                          input string tag);
    int n;
    n = 0;
    while (!rsp_valid && n < 200) begin
      tick();
      n++;
    end
    check_val({tag, "_valid"}, rsp_valid, 1);
    check_val({tag, "_id"}, rsp_id, exp_id);
    check_val({tag, "_prod"}, rsp_product, exp_prod);
    check_val({tag, "_err"}, rsp_err, exp_err);
  endtask

  task automatic check_reset_outs(input string tag);
    check_val({tag, "_req_ready"}, req_ready, 0);
    check_val({tag, "_rsp_valid"}, rsp_valid, 0);
    check_val({tag, "_rsp_id"}, rsp_id, 0);
    check_val({tag, "_rsp_prod"}, rsp_product, 0);
    check_val({tag, "_rsp_err"}, rsp_err, 0);
    check_val({tag, "_eng_start"}, eng_start, 0);
    check_val({tag, "_eng_data"}, eng_data, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad;
    int n;
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    done_en   = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check_reset_outs("rst");

    // Single request from requester 2: 3 * 7
    set_op(2, 16'd3, 16'd7);
    req_valid = 4'b0100;
    grant_wait(2, "t1_grant");
    tick();
    req_valid = '0;
    check_val("t1_start", eng_start, 1);
    check_val("t1_ready_once", req_ready, 0);
    tick();
    check_val("t1_ldq", eng_data, 16'd7);
    check_val("t1_ldq_nostart", eng_start, 0);
    tick();
    check_val("t1_ldm", eng_data, 16'd3);
    tick();
    check_val("t1_wait_data", eng_data, 0);
    rsp_wait(2, 32'd21, 1'b0, "t1");
    tick();
    check_val("t1_rsp_done", rsp_valid, 0);

    // Signed: -5 * 4
    set_op(0, 16'hFFFB, 16'd4);
    req_valid = 4'b0001;
    grant_wait(0, "t2_grant");
    tick();
    req_valid = '0;
    rsp_wait(0, 32'hFFFF_FFEC, 1'b0, "t2");
    tick();

    // All requesters valid from reset: grants 0,1,2,3,0
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_op(i, WIDTH'(i + 1), WIDTH'(i + 2));
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      grant_wait(k % 4, $sformatf("t3_grant%0d", k));
      tick();
      rsp_wait(k % 4, 32'(((k % 4) + 1) * ((k % 4) + 2)), 1'b0, $sformatf("t3_rsp%0d", k));
      tick();
    end
    req_valid = '0;

    // Response back-pressure: 6 * -2 held in RESP while requester 3 waits
    rsp_ready = 1'b0;
    set_op(1, 16'd6, 16'hFFFE);
    set_op(3, 16'd5, 16'd5);
    req_valid = 4'b1010;
    grant_wait(1, "t4_grant");
    tick();
    req_valid = 4'b1000;
    rsp_wait(1, 32'hFFFF_FFF4, 1'b0, "t4");
    for (int c = 0; c < 10; c++) begin
      tick();
      check_val("t4_hold_valid", rsp_valid, 1);
      check_val("t4_hold_id", rsp_id, 1);
      check_val("t4_hold_prod", rsp_product, 32'hFFFF_FFF4);
      check_val("t4_no_grant", req_ready, 0);
    end
    rsp_ready = 1'b1;
    tick();
    check_val("t4_released", rsp_valid, 0);
    grant_wait(3, "t4_next_grant");
    tick();
    req_valid = '0;
    rsp_wait(3, 32'd25, 1'b0, "t4b");
    tick();

    // Reset during WAIT (ptr is 3 after granting 2)
    set_op(2, 16'd1, 16'd1);
    req_valid = 4'b0100;
    grant_wait(2, "t5_grant");
    tick();
    req_valid = '0;
    done_en   = 1'b0;
    tick();
    tick();
    tick();
    check_val("t5_in_wait", eng_data, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outs("t5_rst");
    done_en = 1'b1;
    bad = 0;
    repeat (20) begin
      tick();
      if (rsp_valid || eng_start) bad++;
    end
    check_val("t5_no_spurious", bad, 0);
    set_op(0, 16'd2, 16'd3);
    set_op(3, 16'd9, 16'd9);
    req_valid = 4'b1001;
    grant_wait(0, "t5_ptr_reset");
    tick();
    req_valid = '0;
    rsp_wait(0, 32'd6, 1'b0, "t5");
    tick();

`ifdef BOOTH_MUL_SCHED_TIMEOUT_EN
    // Engine never finishes: error response 16 cycles after WAIT entry
    done_en = 1'b0;
    set_op(1, 16'd2, 16'd2);
    req_valid = 4'b0010;
    grant_wait(1, "t6_grant");
    tick();
    req_valid = '0;
    tick();
    tick();
    tick();
    n = 0;
    while (!rsp_valid && n < 100) begin
      tick();
      n++;
    end
    check_val("t6_timeout_cycles", n, 16);
    check_val("t6_err", rsp_err, 1);
    check_val("t6_prod", rsp_product, 0);
    tick();
    done_en = 1'b1;
`else
    n = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
